// File: rtl/ex_fsm.sv
// Four-state control FSM that follows one full rise/fall/rise/fall cycle of A
// and drives registered flags: k2 during the second high phase, k1 on completion.
module ex_fsm (
  input  logic sclk,
  input  logic rst_n,
  input  logic A,
  output logic k1,
  output logic k2
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    STOP  = 4'b0100,
    CLEAR = 4'b1000
  } state_e;

  state_e state_q, state_d;
  logic   k1_q, k1_d;
  logic   k2_q, k2_d;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
    end
  end

  // Flags change only on the listed transitions; otherwise they hold.
  always_comb begin
    state_d = state_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    case (state_q)
      IDLE: begin
        if (A) begin
          state_d = START;
          k1_d    = 1'b0;
        end
      end
      START: begin
        if (!A) state_d = STOP;
      end
      STOP: begin
        if (A) begin
          state_d = CLEAR;
          k2_d    = 1'b1;
        end
      end
      CLEAR: begin
        if (!A) begin
          state_d = IDLE;
          k2_d    = 1'b0;
          k1_d    = 1'b1;
        end
      end
      // Any illegal one-hot pattern falls back to a clean idle.
      default: begin
        state_d = IDLE;
        k1_d    = 1'b0;
        k2_d    = 1'b0;
      end
    endcase
  end

  assign k1 = k1_q;
  assign k2 = k2_q;

endmodule

// File: tb/tb_ex_fsm.sv
// Directed bench for ex_fsm: reset, full sequence, pulses, hold and async reset.
module tb_ex_fsm;

  logic sclk;
  logic rst_n;
  logic A;
  logic k1;
  logic k2;

  int errors = 0;
  int checks = 0;

  ex_fsm dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .A     (A),
    .k1    (k1),
    .k2    (k2)
  );

  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply A, let one rising edge sample it, then check both flags on the falling edge.
  task automatic cyc(input logic a, input logic ek1, input logic ek2, input string tag);
    A = a;
    @(posedge sclk);
    @(negedge sclk);
    check({tag, "_k1"}, k1, ek1);
    check({tag, "_k2"}, k2, ek2);
    check({tag, "_excl"}, k1 & k2, 1'b0);
  endtask

  function automatic logic sched(input int i);
    if (i < 50)       return 1'b0;
    else if (i < 300) return 1'b1;
    else if (i < 500) return 1'b0;
    else if (i < 700) return 1'b1;
    else              return 1'b0;
  endfunction

  initial begin
    rst_n = 1'b0;
    A     = 1'b0;

    // Reset held for 100 ns with the clock running.
    for (int r = 0; r < 5; r++) begin
      @(negedge sclk);
      check("rst_k1", k1, 1'b0);
      check("rst_k2", k2, 1'b0);
    end
    rst_n = 1'b1;

    while ($time < 200) @(negedge sclk);

    // Full sequence: A launched for edge i is sampled at edge i+1.
    for (int i = 0; i < 800; i++) begin
      A = sched(i);
      @(posedge sclk);
      @(negedge sclk);
      check("seq_k2", k2, ((i + 1) >= 501 && (i + 1) <= 700) ? 1'b1 : 1'b0);
      check("seq_k1", k1, ((i + 1) >= 701) ? 1'b1 : 1'b0);
      check("seq_excl", k1 & k2, 1'b0);
    end

    // Second sequence start clears k1; then walk it to completion.
    cyc(1'b1, 1'b0, 1'b0, "seq2_start");
    cyc(1'b0, 1'b0, 1'b0, "seq2_stop");
    cyc(1'b1, 1'b0, 1'b1, "seq2_clear");
    cyc(1'b0, 1'b1, 1'b0, "seq2_idle");

    // Single-cycle alternating pulses step one state per edge.
    cyc(1'b1, 1'b0, 1'b0, "pulse_start");
    cyc(1'b0, 1'b0, 1'b0, "pulse_stop");
    cyc(1'b1, 1'b0, 1'b1, "pulse_clear");
    cyc(1'b0, 1'b1, 1'b0, "pulse_idle");
    cyc(1'b0, 1'b1, 1'b0, "idle_hold");

    // Reach CLEAR with held levels, then hold A=1 for 1000 cycles.
    cyc(1'b1, 1'b0, 1'b0, "h_start");
    cyc(1'b1, 1'b0, 1'b0, "h_start_hold");
    cyc(1'b0, 1'b0, 1'b0, "h_stop");
    cyc(1'b0, 1'b0, 1'b0, "h_stop_hold");
    cyc(1'b1, 1'b0, 1'b1, "h_clear");
    for (int h = 0; h < 1000; h++) cyc(1'b1, 1'b0, 1'b1, "clear_hold");
    cyc(1'b0, 1'b1, 1'b0, "h_idle");
    cyc(1'b1, 1'b0, 1'b0, "h2_start");
    cyc(1'b0, 1'b0, 1'b0, "h2_stop");
    cyc(1'b1, 1'b0, 1'b1, "h2_clear");

    // Asynchronous reset between edges while in CLEAR.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_k2", k2, 1'b0);
    check("arst_k1", k1, 1'b0);
    @(negedge sclk);
    check("arst_hold_k2", k2, 1'b0);
    rst_n = 1'b1;

    // First edge after release evaluates from IDLE with A=1.
    cyc(1'b1, 1'b0, 1'b0, "post_rst_start");
    cyc(1'b0, 1'b0, 1'b0, "post_rst_stop");
    cyc(1'b1, 1'b0, 1'b1, "post_rst_clear");
    cyc(1'b0, 1'b1, 1'b0, "post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_fsm.md
# ex_fsm

Four-state Moore-style control FSM that tracks the level history of a single control input `A` and drives two registered flags, `k1` and `k2`. The FSM walks one full cycle of `A`: rise, fall, rise, fall. `k2` is high during the second high phase of `A`. `k1` is set when the FSM returns to idle and is cleared when the next sequence starts. It is a self-contained leaf block driven by the system clock, with no handshake to neighbouring logic.

## Interface
- No parameters.
- `sclk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low. Assertion immediately forces the reset state; deassertion is released synchronously to `sclk` by the upstream reset logic.
- `A`  input  1  control level; synchronous to `sclk` and sampled on every rising edge.
- `k1`  output  1  registered flag, set on completion of a full sequence.
- `k2`  output  1  registered flag, high during the second high phase of `A`.

## Operation
- States: IDLE, START, STOP, CLEAR.
  - The encoding is free (one-hot recommended).
  - Undefined encodings recover to IDLE on the next edge, with `k1`/`k2` cleared.
- Transitions are evaluated on each rising edge using the sampled `A`:
  - IDLE: if A=1, go to START and clear `k1` to 0; otherwise stay, with outputs held.
  - START: if A=0, go to STOP; otherwise stay. Outputs are held.
  - STOP: if A=1, go to CLEAR and set `k2` to 1; otherwise stay.
  - CLEAR: if A=0, go to IDLE, clear `k2` to 0 and set `k1` to 1; otherwise stay.
- `k1` and `k2` are flops updated only on the transitions listed above; they are never derived combinationally from state or `A`.
- Invariant: `k2`=1 exactly while the state is CLEAR.
- `k1` holds 1 from the CLEAR→IDLE transition until the next IDLE→START transition.
- `k1` and `k2` are never both 1.
- Repeated sequences behave identically; there is no counting or saturation.

## Timing
- Reset (`rst_n`=0): state=IDLE, `k1`=0, `k2`=0, asynchronously.
  - This holds regardless of `A`, including mid-sequence.
  - After release, the first edge evaluates normally from IDLE.
  - If `A`=1 at the first edge after release, the FSM goes to START on that edge.
- Latency: a level change on `A` that is sampled at edge N changes the state and outputs at edge N. Relative to the edge that launched `A`, this is one cycle later.
- Each edge advances the FSM by at most one transition; a 1-cycle pulse on `A` advances it by exactly one step.
- Holding `A` at a level produces no further transitions.
- Glitch-free outputs: each output toggles at most once per edge, directly from a flop.

## Test plan
- Reset check: hold `rst_n`=0 for 100 ns with `A`=0 and the clock running at a 20 ns period → `k1`=0 and `k2`=0 throughout. Assert `rst_n` low asynchronously between edges mid-CLEAR → `k2` drops to 0 immediately, without waiting for a clock edge.
- Full sequence: after reset, drive `A` from the launching edge index i (0 = first edge at or after 200 ns) as follows:
  - 0 for i<50
  - 1 for 50≤i<300
  - 0 for 300≤i<500
  - 1 for 500≤i<700
  - 0 thereafter
  
  Required responses:
  - State goes to START at i=51, STOP at i=301, CLEAR at i=501, and IDLE at i=701.
  - `k2`=1 from i=501 to i=700 inclusive, and 0 otherwise.
  - `k1`=0 until i=700 and 1 from i=701 onward, stable to the end of the run.
- Second sequence clears `k1`: continue from the previous scenario with `A`=1 for one cycle → `k1` returns to 0 on the next edge and the state is START.
- Single-cycle pulses: apply four alternating one-cycle levels on `A` (1,0,1,0) → the FSM steps one state per edge: START, STOP, CLEAR (`k2`=1 for one cycle), IDLE (`k1`=1).
- Hold behaviour: hold `A`=1 for 1000 cycles in CLEAR → `k2` stays 1 and `k1` stays 0 with no state change.
- Invariant checks throughout all runs:
  - `k1` and `k2` are never both 1.
  - `k2` equals (state==CLEAR) on every cycle.
